// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix interface, used by both the
// keypad emulator and the row-scanning decoder.
//   - state_t        : emulator FSM state encodings
//   - ROW0_N..ROW3_N : one-cold, active-low row drive patterns
//   - KEY_0..KEY_F   : key-code constants
//   - key_to_rc()    : key code -> {row idx[1:0], col idx[1:0]}; also the
//                      decoder's reference table
//   - row_pattern()  : row idx -> active-low one-cold row drive
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_PRESS  = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Row r is selected when the scanner drives this pattern; row 0 is the
  // MSB-low pattern, so the ordering reads left to right on the bus.
  localparam logic [3:0] ROW0_N = 4'b0111;
  localparam logic [3:0] ROW1_N = 4'b1011;
  localparam logic [3:0] ROW2_N = 4'b1101;
  localparam logic [3:0] ROW3_N = 4'b1110;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Physical pad layout: the bottom row is E,0,F,D rather than a
  // straight continuation of the numeric order.
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      KEY_1:   rc = {2'd0, 2'd0};
      KEY_2:   rc = {2'd0, 2'd1};
      KEY_3:   rc = {2'd0, 2'd2};
      KEY_A:   rc = {2'd0, 2'd3};
      KEY_4:   rc = {2'd1, 2'd0};
      KEY_5:   rc = {2'd1, 2'd1};
      KEY_6:   rc = {2'd1, 2'd2};
      KEY_B:   rc = {2'd1, 2'd3};
      KEY_7:   rc = {2'd2, 2'd0};
      KEY_8:   rc = {2'd2, 2'd1};
      KEY_9:   rc = {2'd2, 2'd2};
      KEY_C:   rc = {2'd2, 2'd3};
      KEY_E:   rc = {2'd3, 2'd0};
      KEY_0:   rc = {2'd3, 2'd1};
      KEY_F:   rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};
    endcase
    return rc;
  endfunction

  function automatic logic [3:0] row_pattern(input logic [1:0] ridx);
    logic [3:0] pat;
    case (ridx)
      2'd0:    pat = ROW0_N;
      2'd1:    pat = ROW1_N;
      2'd2:    pat = ROW2_N;
      default: pat = ROW3_N;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_emu_map.sv
// Combinational key-to-column responder.
// Ports:
//   key_q  in  4  key currently held by the emulator
//   row    in  4  live scanner row drive, active low, one-cold
//   enable in  1  contact closed this cycle
//   column out 4  active-low column lines, 4'b1111 = no key
// Only an exact match of the key's one-cold row pattern closes the contact;
// idle rows and multi-row drives leave all columns released.
module keypad_emu_map
  import keypad_pkg::*;
(
  input  logic [3:0] key_q,
  input  logic [3:0] row,
  input  logic       enable,
  output logic [3:0] column
);

  logic [3:0] rc;

  // Zero-latency response so a scanner that moves row on one edge and
  // samples column on the next always sees the matching column.
  always_comb begin
    rc     = key_to_rc(key_q);
    column = 4'b1111;
    if (enable && (row == row_pattern(rc[3:2]))) begin
      column[rc[1:0]] = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side model of the 4x4 matrix: accepts key codes over valid/ready
// and holds each key pressed for PRESS_CYCLES, then released for GAP_CYCLES.
// Optional feature macro: KEYPAD_EMU_BOUNCE_EN inserts a BOUNCE phase of
// BOUNCE_CYCLES before PRESS in which the contact alternates closed/open.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  synchronous reset, active low
//   key_in    in  4  key code to press
//   key_valid in  1  key_in valid
//   key_ready out 1  high when a new code can be accepted (IDLE)
//   row       in  4  scanner row drive, active low, one-cold
//   column    out 4  column lines, active low, 4'b1111 = no key
//   pressed   out 1  high in PRESS (and BOUNCE)
//   busy      out 1  high whenever not IDLE
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES  = 64,
  parameter int GAP_CYCLES    = 32,
  parameter int BOUNCE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic       pressed,
  output logic       busy
);

  // Reject parameter sets the phase counter cannot represent.
  if (PRESS_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 2 ||
      PRESS_CYCLES > (1 << CNT_W) || GAP_CYCLES > (1 << CNT_W) ||
      BOUNCE_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("keypad_emulator: phase lengths out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
`endif

  state_t           state;
  logic [3:0]       key_q;
  logic [CNT_W-1:0] cnt;
  logic             col_en;

  // Phase sequencer: each phase loads N-1 on entry and advances when the
  // counter reaches zero, giving exactly N cycles per phase. Status outputs
  // are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_q     <= '0;
      cnt       <= '0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid && key_ready) begin
            key_q     <= key_in;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            pressed   <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            state     <= ST_BOUNCE;
            cnt       <= BOUNCE_LOAD;
`else
            state     <= ST_PRESS;
            cnt       <= PRESS_LOAD;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        ST_BOUNCE: begin
          if (cnt == '0) begin
            state <= ST_PRESS;
            cnt   <= PRESS_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        ST_PRESS: begin
          if (cnt == '0) begin
            state   <= ST_GAP;
            cnt     <= GAP_LOAD;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
          pressed   <= 1'b0;
        end
      endcase
    end
  end

  // Contact closure: steady in PRESS; during BOUNCE it closes only on odd
  // counter values, so the first bounce cycle is closed.
`ifdef KEYPAD_EMU_BOUNCE_EN
  assign col_en = (state == ST_PRESS) || ((state == ST_BOUNCE) && cnt[0]);
`else
  assign col_en = (state == ST_PRESS);
`endif

  keypad_emu_map u_map (
    .key_q  (key_q),
    .row    (row),
    .enable (col_en),
    .column (column)
  );

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: randomized row drive and key
// codes compared against a timeline/key-layout reference model.
module tb_keypad_emulator;

  localparam int P = 64;
  localparam int G = 32;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B = 8;
`else
  localparam int B = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] row;
  logic [3:0] column;
  logic       pressed;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] layout [4][4];
  int         key_r [16];
  int         key_c [16];

  always #5 clk = ~clk;

  keypad_emulator #(
    .PRESS_CYCLES  (P),
    .GAP_CYCLES    (G),
    .BOUNCE_CYCLES (8),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .row       (row),
    .column    (column),
    .pressed   (pressed),
    .busy      (busy)
  );

  // Row r is selected by the pattern with bit (3-r) low.
  function automatic logic [3:0] pat(input int r);
    logic [3:0] one;
    one = 4'b1000 >> r;
    return ~one;
  endfunction

  function automatic logic [3:0] expColumn(input logic [3:0] k, input logic [3:0] rw, input bit act);
    logic [3:0] c;
    c = 4'hF;
    if (act && rw == pat(key_r[k])) c[key_c[k]] = 1'b0;
    return c;
  endfunction

  function automatic logic [3:0] randRow();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel < 4) return pat(sel);
    if (sel == 4) return 4'hF;
    return 4'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] ecol, input logic erdy,
                             input logic ebusy, input logic epress);
    checks++;
    assert (column === ecol) else begin
      failures++;
      $error("[TB] FAIL %s column=%b expected=%b", tag, column, ecol);
    end
    checks++;
    assert (key_ready === erdy) else begin
      failures++;
      $error("[TB] FAIL %s key_ready=%b expected=%b", tag, key_ready, erdy);
    end
    checks++;
    assert (busy === ebusy) else begin
      failures++;
      $error("[TB] FAIL %s busy=%b expected=%b", tag, busy, ebusy);
    end
    checks++;
    assert (pressed === epress) else begin
      failures++;
      $error("[TB] FAIL %s pressed=%b expected=%b", tag, pressed, epress);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [3:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // mode 0: random rows, 1: key's row alternating with 0111, 2: fixed 0111.
  // t counts cycles since acceptance; the model derives phase from t.
  task automatic runKey(input logic [3:0] k, input int mode, input int inj_t, input logic [3:0] inj_key);
    logic [3:0] rw;
    bit in_b, in_p, act, bsy;
    applyStimulus(k);
    for (int t = 0; t <= B + P + G; t++) begin
      case (mode)
        0:       rw = randRow();
        1:       rw = (t % 2 == 0) ? pat(key_r[k]) : 4'b0111;
        default: rw = 4'b0111;
      endcase
      row = rw;
      if (t == inj_t) begin
        key_in    = inj_key;
        key_valid = 1'b1;
      end
      #1;
      in_b = (t < B);
      in_p = (t >= B) && (t < B + P);
      bsy  = (t < B + P + G);
      act  = in_p || (in_b && ((B - 1 - t) % 2 == 1));
      checkOutput($sformatf("key%h_t%0d", k, t), expColumn(k, rw, act), !bsy, bsy, in_b || in_p);
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int order [16];
    int fr, fc, found, n, tmp, j;
    logic [4:0] decoded;
    logic [3:0] code;

    layout = '{'{4'h1, 4'h2, 4'h3, 4'hA},
               '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC},
               '{4'hE, 4'h0, 4'hF, 4'hD}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        key_r[layout[r][c]] = r;
        key_c[layout[r][c]] = c;
      end

    // Reset with row idle-pattern and with key 0's row: nothing pressed.
    rst_n = 1'b0; key_valid = 1'b0; key_in = 4'h0; row = 4'b0111;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", 4'hF, 1'b1, 1'b0, 1'b0);
    row = 4'b1110;
    #1;
    checkOutput("reset_row3", 4'hF, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Key 5 with its row alternating against row 0.
    runKey(4'h5, 1, -1, 4'h0);

    // Random keys under random row drive.
    repeat (3) runKey(4'($urandom_range(0, 15)), 0, -1, 4'h0);

    // Key 9 offered while busy with 7 must be ignored.
    runKey(4'h7, 0, B + 5, 4'h9);

    // Full map via a scanner model: find the closed row/column, decode.
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      code = 4'(order[i]);
      row = 4'hF;
      applyStimulus(code);
      repeat (B + 2) @(negedge clk);
      found = 0; fr = 0; fc = 0;
      for (int r = 0; r < 4; r++) begin
        row = pat(r);
        #1;
        if (column != 4'hF) begin
          found++;
          fr = r;
          for (int c = 0; c < 4; c++) if (!column[c]) fc = c;
        end
        @(negedge clk);
      end
      decoded = (found == 1) ? {1'b0, layout[fr][fc]} : 5'h10;
      checks++;
      assert (decoded === {1'b0, code}) else begin
        failures++;
        $error("[TB] FAIL map_scan decoded=%h expected=%h", decoded, code);
      end
      row = 4'hF;
      n = 0;
      while (!key_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      checks++;
      assert (key_ready === 1'b1) else begin
        failures++;
        $error("[TB] FAIL map_ready key_ready=%b expected=1", key_ready);
      end
    end

    // Reset in the middle of a D press: release at once, no gap.
    row = 4'b1110;
    applyStimulus(4'hD);
    repeat (B + 10) @(negedge clk);
    #1;
    checkOutput("d_before_reset", 4'b0111, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_mid_press", 4'hF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("reset_mid_press2", 4'hF, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("after_reset", 4'hF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    runKey(4'($urandom_range(0, 15)), 0, -1, 4'h0);

    // Key 1 on row 0: bounce alternation (when enabled) then steady press.
    runKey(4'h1, 2, -1, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
